countdown_timer: RTL and testbench

- Countdown counterpart to the stopwatch in the digital clock: loads an MM:SS value, counts it down once per second, and flags expiry.
- Drives the same 4-digit display path as the clock and stopwatch, using BCD digit outputs.
- Raises a level `done` flag and a fixed-length `alarm` pulse for the buzzer.

---
 rtl/timer_pkg.sv | 31 +++
 rtl/countdown_timer_if.sv | 29 ++
 rtl/bcd_mmss_down.sv | 52 +++++
 rtl/countdown_timer.sv | 135 +++++++++++++
 tb/tb_countdown_timer.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/timer_pkg.sv
// Purpose: shared types, limits and BCD helper for the MM:SS countdown timer.
// Latency: n/a (types, constants and a pure combinational function).
// Backpressure: n/a.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } timer_state_e;

  localparam int MAX_MIN = 99;
  localparam int MAX_SEC = 59;

  // Binary 0..99 to {tens, ones} BCD. Callers clamp before calling, so
  // the tens search tops out at 9.
  function automatic logic [7:0] bin_to_bcd2(input logic [6:0] bin);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = 4'd0;
    for (int k = 1; k <= 9; k++) begin
      if (bin >= 7'(k * 10)) tens = 4'(k);
    end
    // The true remainder is below 10, so arithmetic modulo 16 on the low
    // nibble is exact: ones = bin - 10*tens, with 10*tens = 8*tens + 2*tens.
    ones = bin[3:0] - ({tens[0], 3'b000} + {tens[2:0], 1'b0});
    return {tens, ones};
  endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// Purpose: control and display bundle between a host and the countdown timer.
// Latency: n/a (wires only).
// Backpressure: none; controls are sampled every clk, outputs are always valid.
// Ports: master drives load/set_min/set_sec/start/pause and reads the BCD
//        digits plus running/done/alarm; slave is the timer side.
interface countdown_timer_if;
  logic       load;
  logic [6:0] set_min;
  logic [5:0] set_sec;
  logic       start;
  logic       pause;
  logic [3:0] min_tens;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       running;
  logic       done;
  logic       alarm;

  modport master (
    output load, set_min, set_sec, start, pause,
    input  min_tens, min_ones, sec_tens, sec_ones, running, done, alarm
  );

  modport slave (
    input  load, set_min, set_sec, start, pause,
    output min_tens, min_ones, sec_tens, sec_ones, running, done, alarm
  );
endinterface

// File: rtl/bcd_mmss_down.sv
// Purpose: MM:SS BCD register with a one-second borrow-chain decrement and zero detect.
// Latency: load/decrement visible one clk after the enabling edge.
// Backpressure: none; dec_en at 00:00 is ignored so the value never wraps.
// Ports: clk, restart (sync, highest priority), load_en + load_digits
//        {mt,mo,st,so}, dec_en; outputs the four digits and is_zero.
module bcd_mmss_down (
  input  logic        clk,
  input  logic        restart,
  input  logic        load_en,
  input  logic [15:0] load_digits,
  input  logic        dec_en,
  output logic [3:0]  min_tens,
  output logic [3:0]  min_ones,
  output logic [3:0]  sec_tens,
  output logic [3:0]  sec_ones,
  output logic        is_zero
);

  assign is_zero = (min_tens == 4'd0) && (min_ones == 4'd0) &&
                   (sec_tens == 4'd0) && (sec_ones == 4'd0);

  always_ff @(posedge clk) begin
    if (restart) begin
      min_tens <= 4'd0;
      min_ones <= 4'd0;
      sec_tens <= 4'd0;
      sec_ones <= 4'd0;
    end else if (load_en) begin
      {min_tens, min_ones, sec_tens, sec_ones} <= load_digits;
    end else if (dec_en && !is_zero) begin
      // Each digit borrows from the next one up only when it is at zero;
      // seconds-tens wraps to 5, the other digits wrap to 9.
      if (sec_ones != 4'd0) begin
        sec_ones <= sec_ones - 4'd1;
      end else begin
        sec_ones <= 4'd9;
        if (sec_tens != 4'd0) begin
          sec_tens <= sec_tens - 4'd1;
        end else begin
          sec_tens <= 4'd5;
          if (min_ones != 4'd0) begin
            min_ones <= min_ones - 4'd1;
          end else begin
            min_ones <= 4'd9;
            min_tens <= min_tens - 4'd1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// Purpose: MM:SS countdown with one-second prescaler, level done and timed alarm pulse.
// Latency: start/pause/load take effect on the sampling edge; first decrement TICK_DIV clks after RUN entry.
// Backpressure: none; priority restart > load > start > pause, unused commands ignored.
// Ports: clk, restart (sync active-high), bus (countdown_timer_if.slave).
// TICK_DIV must be >= 2 and ALARM_CYCLES >= 1.
module countdown_timer #(
  parameter int TICK_DIV     = 50_000_000,
  parameter int ALARM_CYCLES = 25_000_000
) (
  input  logic              clk,
  input  logic              restart,
  countdown_timer_if.slave  bus
);

  import timer_pkg::*;

  localparam int             PW         = $clog2(TICK_DIV);
  localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);
  localparam int             AW         = $clog2(ALARM_CYCLES + 1);
  localparam logic [AW-1:0]  ALARM_LOAD = AW'(ALARM_CYCLES - 1);

  timer_state_e   state;
  logic [PW-1:0]  presc;
  logic [AW-1:0]  alarm_cnt;
  logic           running_q;
  logic           done_q;
  logic           alarm_q;

  logic [6:0]     min_c;
  logic [5:0]     sec_c;
  logic [15:0]    load_digits;
  logic [3:0]     mt, mo, st, so;
  logic           is_zero;
  logic           pause_eff;
  logic           tick;
  logic           last_sec;
  logic           dec_en;

  // Out-of-range presets saturate rather than producing non-BCD digits.
  assign min_c = (bus.set_min > 7'(MAX_MIN)) ? 7'(MAX_MIN) : bus.set_min;
  assign sec_c = (bus.set_sec > 6'(MAX_SEC)) ? 6'(MAX_SEC) : bus.set_sec;
  assign load_digits = {bin_to_bcd2(min_c), bin_to_bcd2({1'b0, sec_c})};

  // start wins over pause when both are high.
  assign pause_eff = bus.pause && !bus.start;
  // A pause edge freezes the prescaler, so no tick can land on it.
  assign tick      = (state == RUN) && !pause_eff && (presc == PRESC_LAST);
  assign dec_en    = tick;
  // The tick that leaves 00:00 behind is the one that finds 00:01.
  assign last_sec  = ({mt, mo, st, so} == 16'h0001);

  bcd_mmss_down u_digits (
    .clk         (clk),
    .restart     (restart),
    .load_en     (bus.load),
    .load_digits (load_digits),
    .dec_en      (dec_en),
    .min_tens    (mt),
    .min_ones    (mo),
    .sec_tens    (st),
    .sec_ones    (so),
    .is_zero     (is_zero)
  );

  always_ff @(posedge clk) begin
    if (restart) begin
      state     <= IDLE;
      presc     <= '0;
      alarm_cnt <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      alarm_q   <= 1'b0;
    end else if (bus.load) begin
      state     <= IDLE;
      presc     <= '0;
      alarm_cnt <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      alarm_q   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start && !is_zero) begin
            state     <= RUN;
            presc     <= '0;
            running_q <= 1'b1;
          end
        end
        RUN: begin
          if (pause_eff) begin
            state     <= PAUSED;
            running_q <= 1'b0;
          end else if (tick) begin
            presc <= '0;
            if (last_sec) begin
              state     <= EXPIRED;
              running_q <= 1'b0;
              done_q    <= 1'b1;
              alarm_q   <= 1'b1;
              alarm_cnt <= ALARM_LOAD;
            end
          end else begin
            presc <= presc + PW'(1);
          end
        end
        PAUSED: begin
          // Prescaler is left alone so a partial second survives the pause.
          if (bus.start) begin
            state     <= RUN;
            running_q <= 1'b1;
          end
        end
        EXPIRED: begin
          // alarm_cnt counts the remaining high cycles after the expiry edge.
          if (alarm_q) begin
            if (alarm_cnt == '0) alarm_q <= 1'b0;
            else                 alarm_cnt <= alarm_cnt - AW'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.min_tens = mt;
  assign bus.min_ones = mo;
  assign bus.sec_tens = st;
  assign bus.sec_ones = so;
  assign bus.running  = running_q;
  assign bus.done     = done_q;
  assign bus.alarm    = alarm_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Purpose: directed self-checking bench for countdown_timer at TICK_DIV=4, ALARM_CYCLES=3.
// Latency: inputs driven and outputs sampled 1 time unit after each posedge.
// Backpressure: n/a.
module tb_countdown_timer;

  logic clk;
  logic restart;
  int   n_cmp;
  int   n_err;

  countdown_timer_if bus ();

  countdown_timer #(
    .TICK_DIV     (4),
    .ALARM_CYCLES (3)
  ) dut (
    .clk     (clk),
    .restart (restart),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [15:0] digits();
    return {bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones};
  endfunction

  task automatic do_load(input logic [6:0] m, input logic [5:0] s);
    bus.set_min = m;
    bus.set_sec = s;
    bus.load    = 1'b1;
    step(1);
    bus.load    = 1'b0;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
  endtask

  initial begin
    n_cmp       = 0;
    n_err       = 0;
    restart     = 1'b1;
    bus.load    = 1'b0;
    bus.set_min = 7'd0;
    bus.set_sec = 6'd0;
    bus.start   = 1'b0;
    bus.pause   = 1'b0;
    step(2);
    check_eq("rst_digits",  32'(digits()),  32'h0000);
    check_eq("rst_running", 32'(bus.running), 32'd0);
    check_eq("rst_done",    32'(bus.done),  32'd0);
    check_eq("rst_alarm",   32'(bus.alarm), 32'd0);
    restart = 1'b0;
    step(1);

    // 00:02 runs to expiry: 00:01 at S+4, 00:00 at S+8, alarm S+8..S+10.
    do_load(7'd0, 6'd2);
    check_eq("ld_0002", 32'(digits()), 32'h0002);
    do_start();
    check_eq("run_after_start", 32'(bus.running), 32'd1);
    step(3);
    check_eq("s3_still_0002", 32'(digits()), 32'h0002);
    step(1);
    check_eq("s4_0001", 32'(digits()), 32'h0001);
    step(3);
    check_eq("s7_done_low", 32'(bus.done), 32'd0);
    step(1);
    check_eq("s8_0000",    32'(digits()), 32'h0000);
    check_eq("s8_done",    32'(bus.done), 32'd1);
    check_eq("s8_alarm",   32'(bus.alarm), 32'd1);
    check_eq("s8_running", 32'(bus.running), 32'd0);
    step(2);
    check_eq("s10_alarm", 32'(bus.alarm), 32'd1);
    step(1);
    check_eq("s11_alarm_off", 32'(bus.alarm), 32'd0);
    check_eq("s11_done",      32'(bus.done), 32'd1);
    step(5);
    check_eq("no_wrap", 32'(digits()), 32'h0000);
    do_start();
    check_eq("exp_ign_start_run",  32'(bus.running), 32'd0);
    check_eq("exp_ign_start_done", 32'(bus.done), 32'd1);

    // Borrow chain across seconds-tens and minutes.
    do_load(7'd1, 6'd0);
    check_eq("ld_clears_done", 32'(bus.done), 32'd0);
    do_start();
    step(4);
    check_eq("borrow_0059", 32'(digits()), 32'h0059);
    do_load(7'd10, 6'd0);
    check_eq("ld_1000", 32'(digits()), 32'h1000);
    do_start();
    step(4);
    check_eq("borrow_0959", 32'(digits()), 32'h0959);

    // Pause keeps the partial second: presc reaches 2 before the pause edge,
    // so after resume only two more edges are needed for the tick.
    do_load(7'd0, 6'd5);
    do_start();
    step(2);
    bus.pause = 1'b1;
    step(1);
    bus.pause = 1'b0;
    check_eq("paused_running", 32'(bus.running), 32'd0);
    step(10);
    check_eq("paused_hold", 32'(digits()), 32'h0005);
    do_start();
    check_eq("resume_running", 32'(bus.running), 32'd1);
    step(1);
    check_eq("resume_r1_0005", 32'(digits()), 32'h0005);
    step(1);
    check_eq("resume_r2_0004", 32'(digits()), 32'h0004);

    // Clamping and zero-value start.
    do_load(7'd120, 6'd63);
    check_eq("clamp_9959", 32'(digits()), 32'h9959);
    do_load(7'd0, 6'd0);
    do_start();
    check_eq("zero_start_running", 32'(bus.running), 32'd0);
    step(5);
    check_eq("zero_start_digits", 32'(digits()), 32'h0000);

    // start+pause together from IDLE resolves as start; restart just after expiry.
    do_load(7'd0, 6'd3);
    bus.start = 1'b1;
    bus.pause = 1'b1;
    step(1);
    bus.start = 1'b0;
    bus.pause = 1'b0;
    check_eq("start_pause_run", 32'(bus.running), 32'd1);
    step(11);
    check_eq("sp_s11_0001", 32'(digits()), 32'h0001);
    step(1);
    check_eq("sp_s12_alarm", 32'(bus.alarm), 32'd1);
    restart = 1'b1;
    step(1);
    restart = 1'b0;
    check_eq("rst_mid_alarm", 32'(bus.alarm), 32'd0);
    check_eq("rst_mid_done",  32'(bus.done), 32'd0);
    check_eq("rst_mid_digits", 32'(digits()), 32'h0000);

    // load mid-RUN: back to IDLE, prescaler restarts from 0 on next start.
    do_load(7'd0, 6'd9);
    do_start();
    step(5);
    check_eq("midrun_0008", 32'(digits()), 32'h0008);
    do_load(7'd0, 6'd7);
    check_eq("midrun_ld_running", 32'(bus.running), 32'd0);
    check_eq("midrun_ld_digits",  32'(digits()), 32'h0007);
    step(3);
    check_eq("midrun_idle_hold", 32'(digits()), 32'h0007);
    do_start();
    step(3);
    check_eq("fresh_presc_s3", 32'(digits()), 32'h0007);
    step(1);
    check_eq("fresh_presc_s4", 32'(digits()), 32'h0006);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
